// File: rtl/boot_loader.sv
// boot_loader
// Reset sequencer and memory preloader for the processor core. After reset
// it holds the core in reset for RESET_CYCLES cycles. It then streams N_CH
// byte images word by word over one shared valid/ready write port, and
// finally releases the core. A start pulse while the core runs re-boots it.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   start            re-boot request, honoured only while the core runs
//   image_i, len_i   byte images and their lengths per channel (stable while busy_o)
//   wr_valid_o, wr_ch_o, wr_addr_o, wr_data_o, wr_ready_i
//                    write beat (little-endian word, word-aligned byte address)
//   core_reset_n_o   active-low reset to the core
//   busy_o           high while holding or loading
//   done_o           one-cycle pulse at boot completion
//   err_o            sticky: a length exceeded MAX_BYTES during this boot
module boot_loader #(
  parameter int N_CH         = 2,
  parameter int WORD_BYTES   = 4,
  parameter int MAX_BYTES    = 64,
  parameter int RESET_CYCLES = 10,
  parameter int ADDR_W       = $clog2(MAX_BYTES)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [N_CH-1:0][MAX_BYTES-1:0][7:0]  image_i,
  input  logic [N_CH-1:0][ADDR_W:0]            len_i,
  output logic                                 wr_valid_o,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch_o,
  output logic [ADDR_W-1:0]                    wr_addr_o,
  output logic [WORD_BYTES*8-1:0]              wr_data_o,
  input  logic                                 wr_ready_i,
  output logic                                 core_reset_n_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o
);

  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int DATA_W = WORD_BYTES * 8;

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [N_CH-1:0][ADDR_W:0]   len_q, len_d;
  logic                        valid_q, valid_d;
  logic [CH_W-1:0]             ch_q, ch_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [DATA_W-1:0]           data_q, data_d;
  logic                        core_rst_n_q, core_rst_n_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;

  logic [N_CH-1:0][ADDR_W:0]   len_clamped;
  logic                        over_max;
  logic [CH_W:0]               pick;
  logic                        to_run;

  // Gathers one little-endian word of a channel image; bytes at or past the
  // image length read as zero. addr is word aligned and MAX_BYTES is a whole
  // number of words, so any byte below len is a legal image index.
  function automatic logic [DATA_W-1:0] pack_word(input logic [CH_W-1:0]   ch,
                                                   input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W:0]   len);
    logic [DATA_W-1:0] w;
    logic [ADDR_W+1:0] idx;
    w = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      idx = {2'b00, addr} + (ADDR_W+2)'(k);
      if (idx < {1'b0, len}) begin
        w[8*k +: 8] = image_i[ch][idx[ADDR_W-1:0]];
      end
    end
    return w;
  endfunction

  // Lowest channel at or above 'from' with a nonzero length: {found, index}.
  function automatic logic [CH_W:0] find_ch(input logic [N_CH-1:0][ADDR_W:0] lens,
                                             input int from);
    logic [CH_W:0] res;
    res = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i >= from && lens[i] != '0) begin
        res = {1'b1, CH_W'(i)};
      end
    end
    return res;
  endfunction

  // Oversized lengths are clamped to the image capacity and flagged.
  always_comb begin
    over_max    = 1'b0;
    len_clamped = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (len_i[i] > (ADDR_W+1)'(MAX_BYTES)) begin
        len_clamped[i] = (ADDR_W+1)'(MAX_BYTES);
        over_max       = 1'b1;
      end else begin
        len_clamped[i] = len_i[i];
      end
    end
  end

  // Sequencer: hold count, beat walk across channels, run/re-boot.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    valid_d      = valid_q;
    ch_d         = ch_q;
    addr_d       = addr_q;
    data_d       = data_q;
    core_rst_n_d = core_rst_n_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    pick         = '0;
    to_run       = 1'b0;

    case (state_q)
      ST_HOLD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          len_d   = len_clamped;
          err_d   = over_max;
          pick    = find_ch(len_clamped, 0);
          // With no nonzero channel, valid stays low and LOAD exits at once.
          if (pick[CH_W]) begin
            valid_d = 1'b1;
            ch_d    = pick[CH_W-1:0];
            addr_d  = '0;
            data_d  = pack_word(pick[CH_W-1:0], '0, len_clamped[pick[CH_W-1:0]]);
          end
        end
      end

      ST_LOAD: begin
        if (!valid_q) begin
          to_run = 1'b1;
        end else if (wr_ready_i) begin
          if (({2'b00, addr_q} + (ADDR_W+2)'(WORD_BYTES)) < {1'b0, len_q[ch_q]}) begin
            addr_d = addr_q + ADDR_W'(WORD_BYTES);
            data_d = pack_word(ch_q, addr_q + ADDR_W'(WORD_BYTES), len_q[ch_q]);
          end else begin
            pick = find_ch(len_q, int'(ch_q) + 1);
            if (pick[CH_W]) begin
              ch_d   = pick[CH_W-1:0];
              addr_d = '0;
              data_d = pack_word(pick[CH_W-1:0], '0, len_q[pick[CH_W-1:0]]);
            end else begin
              to_run = 1'b1;
            end
          end
        end
        if (to_run) begin
          state_d      = ST_RUN;
          valid_d      = 1'b0;
          ch_d         = '0;
          addr_d       = '0;
          data_d       = '0;
          core_rst_n_d = 1'b1;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end
      end

      ST_RUN: begin
        if (start) begin
          state_d      = ST_HOLD;
          cnt_d        = '0;
          core_rst_n_d = 1'b0;
          busy_d       = 1'b1;
          err_d        = 1'b0;
        end
      end

      default: begin
        state_d      = ST_HOLD;
        cnt_d        = '0;
        valid_d      = 1'b0;
        core_rst_n_d = 1'b0;
        busy_d       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      len_q        <= '0;
      valid_q      <= 1'b0;
      ch_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      valid_q      <= valid_d;
      ch_q         <= ch_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign wr_valid_o     = valid_q;
  assign wr_ch_o        = ch_q;
  assign wr_addr_o      = addr_q;
  assign wr_data_o      = data_q;
  assign core_reset_n_o = core_rst_n_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader
// Directed bench for boot_loader with default parameters. Expected write
// beats are queued when each boot is set up; a negedge monitor pops and
// compares them on every handshake, and checks stalled beats stay stable.
module tb_boot_loader;

  localparam int RC = 10;

  typedef struct packed {
    logic [0:0]  ch;
    logic [5:0]  addr;
    logic [31:0] data;
  } beat_t;

  logic                  clk;
  logic                  reset_n;
  logic                  start;
  logic [1:0][63:0][7:0] image;
  logic [1:0][6:0]       lens;
  logic                  wr_valid;
  logic [0:0]            wr_ch;
  logic [5:0]            wr_addr;
  logic [31:0]           wr_data;
  logic                  wr_ready;
  logic                  core_reset_n;
  logic                  busy;
  logic                  done;
  logic                  err;

  beat_t expQ[$];
  int    errors = 0;
  int    checks = 0;
  int    hsCount = 0;
  bit    stalled = 0;
  beat_t held;

  boot_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .image_i        (image),
    .len_i          (lens),
    .wr_valid_o     (wr_valid),
    .wr_ch_o        (wr_ch),
    .wr_addr_o      (wr_addr),
    .wr_data_o      (wr_data),
    .wr_ready_i     (wr_ready),
    .core_reset_n_o (core_reset_n),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Expected beats of one channel, built byte by byte from the bench image.
  task automatic pushModel(input int c, input int len);
    int    lc;
    beat_t b;
    lc = (len > 64) ? 64 : len;
    for (int a = 0; a < lc; a += 4) begin
      b.ch   = 1'(c);
      b.addr = 6'(a);
      b.data = '0;
      for (int k = 0; k < 4; k++) begin
        if (a + k < lc) b.data[8*k +: 8] = image[c][a+k];
      end
      expQ.push_back(b);
    end
  endtask

  task automatic applyStimulus(input int l0, input int l1);
    lens[0] = 7'(l0);
    lens[1] = 7'(l1);
    pushModel(0, l0);
    pushModel(1, l1);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expQ.delete();
  endtask

  task automatic doStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("start core_reset_n", core_reset_n, 1'b0);
    checkOutput("start busy", busy, 1'b1);
    checkOutput("start done", done, 1'b0);
    checkOutput("start err cleared", err, 1'b0);
  endtask

  // Walks one boot edge by edge (edge 1 is the first edge of HOLD) and checks
  // the release timing; bp applies a 1,0,0 ready pattern from the first LOAD edge.
  task automatic runSequence(input bit fromReset, input int relEdge, input int expBeats,
                             input bit bp, input bit expErr);
    hsCount = 0;
    if (fromReset) begin
      @(negedge clk);
      reset_n = 1'b1;
    end
    for (int e = 1; e <= relEdge + 2; e++) begin
      if (bp && e > RC) wr_ready = ((e - RC - 1) % 3 == 0);
      else wr_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("core_reset_n edge %0d", e), core_reset_n, e >= relEdge);
      checkOutput($sformatf("busy edge %0d", e), busy, e < relEdge);
      checkOutput($sformatf("done edge %0d", e), done, e == relEdge);
    end
    wr_ready = 1'b1;
    checkOutput("beat count", hsCount, expBeats);
    checkOutput("expected beats left", expQ.size(), 0);
    checkOutput("err in RUN", err, expErr);
  endtask

  // Scoreboard monitor: inputs change #1 after posedge, so at the negedge
  // valid&ready means a handshake on the coming edge.
  always @(negedge clk) begin
    beat_t cur;
    beat_t want;
    if (!reset_n) begin
      stalled = 0;
    end else if (wr_valid) begin
      cur = {wr_ch, wr_addr, wr_data};
      if (stalled) checkOutput("held beat", cur, held);
      if (wr_ready) begin
        hsCount++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected beat: got %0h required none", cur);
        end else begin
          want = expQ.pop_front();
          checkOutput("beat", cur, want);
        end
        stalled = 0;
      end else begin
        stalled = 1;
        held    = cur;
      end
    end else begin
      stalled = 0;
    end
  end

  initial begin
    beat_t b;
    reset_n  = 1'b1;
    start    = 1'b0;
    wr_ready = 1'b1;
    lens     = '0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 64; i++)
        image[c][i] = 8'(16 * (c + 1) + i + 1);
    #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset state");
    checkOutput("reset core_reset_n", core_reset_n, 1'b0);
    checkOutput("reset wr_valid", wr_valid, 1'b0);
    checkOutput("reset busy", busy, 1'b1);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset err", err, 1'b0);
    checkOutput("reset wr_ch", wr_ch, 1'b0);
    checkOutput("reset wr_addr", wr_addr, 6'd0);
    checkOutput("reset wr_data", wr_data, 32'd0);

    $display("[TB] len={16,32} ready=1");
    applyStimulus(16, 32);
    runSequence(1, 22, 12, 0, 0);

    $display("[TB] start re-boot with backpressure");
    applyStimulus(16, 32);
    doStart();
    runSequence(0, 44, 12, 1, 0);

    $display("[TB] len={6,0} partial word");
    doReset();
    lens[0] = 7'd6;
    lens[1] = 7'd0;
    b = {1'b0, 6'd0, 32'h14131211};
    expQ.push_back(b);
    b = {1'b0, 6'd4, 32'h00001615};
    expQ.push_back(b);
    runSequence(1, 12, 2, 0, 0);

    $display("[TB] len={0,0}");
    doReset();
    applyStimulus(0, 0);
    runSequence(1, 11, 0, 0, 0);

    $display("[TB] len={80,8} clamp");
    doReset();
    applyStimulus(80, 8);
    runSequence(1, 28, 18, 0, 1);
    applyStimulus(16, 32);
    doStart();
    runSequence(0, 22, 12, 0, 0);

    $display("[TB] reset mid-LOAD");
    doReset();
    applyStimulus(16, 32);
    hsCount = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= RC + 3; e++) begin
      wr_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    checkOutput("abort wr_valid", wr_valid, 1'b0);
    checkOutput("abort core_reset_n", core_reset_n, 1'b0);
    checkOutput("abort beats before reset", hsCount, 3);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(16, 32);
    runSequence(1, 22, 12, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
